// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling on a shared baud_tick enable, 2-flop input sync and break handling.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity) and a parity_error pulse.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | confirming the start bit at half-bit
// DATA   | sampling data bits mid-bit, LSB first
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit; good frame or framing error
// BREAK  | stop bit was low; waiting for the line to return high
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic                 rx_line,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 rx_valid,
   output logic                 frame_error,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_error,
`endif
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   state_t state, state_nxt;

   logic                 rx_meta, rx_s, rx_prev;
   logic [TW-1:0]        tick_cnt, tick_nxt;
   logic [BW-1:0]        bit_idx, bit_nxt;
   logic [DATA_BITS-1:0] shift, shift_nxt;
   logic [DATA_BITS-1:0] data_nxt;
   logic                 valid_nxt, ferr_nxt;
   logic                 fall_edge;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit, par_nxt;
   logic                 perr_nxt;
   logic                 par_bad;
`endif

   assign fall_edge = rx_prev & ~rx_s;
   assign busy      = (state != S_IDLE);

`ifdef UART_RX_PARITY_EN
   assign par_bad = ((^shift) ^ par_bit) != PARITY_ODD;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta     <= 1'b1;
         rx_s        <= 1'b1;
         rx_prev     <= 1'b1;
         state       <= S_IDLE;
         tick_cnt    <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         data_out    <= '0;
         rx_valid    <= 1'b0;
         frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit      <= 1'b0;
         parity_error <= 1'b0;
`endif
      end else begin
         rx_meta     <= rx_line;
         rx_s        <= rx_meta;
         rx_prev     <= rx_s;
         state       <= state_nxt;
         tick_cnt    <= tick_nxt;
         bit_idx     <= bit_nxt;
         shift       <= shift_nxt;
         data_out    <= data_nxt;
         rx_valid    <= valid_nxt;
         frame_error <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
         par_bit      <= par_nxt;
         parity_error <= perr_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      tick_nxt  = tick_cnt;
      bit_nxt   = bit_idx;
      shift_nxt = shift;
      data_nxt  = data_out;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_nxt   = par_bit;
      perr_nxt  = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (fall_edge) begin
               state_nxt = S_START;
               tick_nxt  = '0;
            end
         end
         S_START: begin
            if (baud_tick) begin
               if (tick_cnt == HALF_M1) begin
                  tick_nxt  = '0;
                  bit_nxt   = '0;
                  state_nxt = rx_s ? S_IDLE : S_DATA;
               end else begin
                  tick_nxt = tick_cnt + TW'(1);
               end
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               if (tick_cnt == FULL_M1) begin
                  tick_nxt  = '0;
                  shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
                  if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_nxt = S_PARITY;
`else
                     state_nxt = S_STOP;
`endif
                  end else begin
                     bit_nxt = bit_idx + BW'(1);
                  end
               end else begin
                  tick_nxt = tick_cnt + TW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (baud_tick) begin
               if (tick_cnt == FULL_M1) begin
                  tick_nxt  = '0;
                  par_nxt   = rx_s;
                  state_nxt = S_STOP;
               end else begin
                  tick_nxt = tick_cnt + TW'(1);
               end
            end
         end
`endif
         S_STOP: begin
            if (baud_tick) begin
               if (tick_cnt == FULL_M1) begin
                  tick_nxt = '0;
                  if (!rx_s) begin
                     // a low stop bit outranks a parity mismatch
                     ferr_nxt  = 1'b1;
                     state_nxt = S_BREAK;
`ifdef UART_RX_PARITY_EN
                  end else if (par_bad) begin
                     perr_nxt  = 1'b1;
                     state_nxt = S_IDLE;
`endif
                  end else begin
                     valid_nxt = 1'b1;
                     data_nxt  = shift;
                     state_nxt = S_IDLE;
                  end
               end else begin
                  tick_nxt = tick_cnt + TW'(1);
               end
            end
         end
         S_BREAK: begin
            if (rx_s) begin
               state_nxt = S_IDLE;
               tick_nxt  = '0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            tick_nxt  = '0;
         end
      endcase
   end

endmodule
